// File: rtl/mul_arb.sv
`default_nettype none
// ============================================================================
// mul_arb : round-robin sequencer sharing one multi-cycle multiplier among
//           NREQ requesters. Define MUL_ARB_TIMEOUT_EN for a WAIT watchdog.
// Revision: 1.0
// ============================================================================
module mul_arb #(
  parameter int N    = 16,
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*N-1:0] i_a,
  input  logic [NREQ*N-1:0] i_b,
  output logic [NREQ-1:0]   o_gnt,
  output logic [N-1:0]      o_res,
  output logic [NREQ-1:0]   o_res_vld,
  output logic              o_busy,
  output logic              o_mul_vld,
  output logic [N-1:0]      o_mul_a,
  output logic [N-1:0]      o_mul_b,
`ifdef MUL_ARB_TIMEOUT_EN
  output logic              o_err,
`endif
  input  logic [N-1:0]      i_mul_res,
  input  logic              i_mul_vld
);

  localparam int              IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_last;
  logic [IW-1:0] r_sel;

  logic [IW-1:0] w_cand;
  logic [IW-1:0] w_win;
  logic          w_any;
  logic [N-1:0]  w_op_a;
  logic [N-1:0]  w_op_b;

  // Scan from farthest to nearest so the requester just after r_last wins.
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_cand = '0;
    for (int i = NREQ; i >= 1; i--) begin
      w_cand = IW'((int'(r_last) + i) % NREQ);
      if (i_req[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  always_comb begin
    w_op_a = i_a[int'(w_win)*N +: N];
    w_op_b = i_b[int'(w_win)*N +: N];
  end

  assign o_busy = (r_state != IDLE);

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int TIMEOUT = 64;
  localparam int CW      = $clog2(TIMEOUT);

  logic [CW-1:0] r_wcnt;
  logic          w_expired;

  assign w_expired = (r_wcnt == CW'(TIMEOUT - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last    <= IW'(NREQ - 1);
      r_sel     <= '0;
      o_gnt     <= '0;
      o_res     <= '0;
      o_res_vld <= '0;
      o_mul_vld <= 1'b0;
      o_mul_a   <= '0;
      o_mul_b   <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
      o_err     <= 1'b0;
      r_wcnt    <= '0;
`endif
    end else begin
      o_gnt     <= '0;
      o_res_vld <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
      o_err     <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_sel     <= w_win;
            o_gnt     <= ONE << w_win;
            o_mul_vld <= 1'b1;
            o_mul_a   <= w_op_a;
            o_mul_b   <= w_op_b;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          // The multiplier valid is not looked at until WAIT, so a level
          // left over from the previous job cannot finish this one early.
          o_mul_vld <= 1'b0;
          r_state   <= WAIT;
`ifdef MUL_ARB_TIMEOUT_EN
          r_wcnt    <= '0;
`endif
        end
        WAIT: begin
          if (i_mul_vld) begin
            o_res     <= i_mul_res;
            o_res_vld <= ONE << r_sel;
            r_last    <= r_sel;
            r_state   <= IDLE;
          end
`ifdef MUL_ARB_TIMEOUT_EN
          else if (w_expired) begin
            o_res     <= '0;
            o_res_vld <= ONE << r_sel;
            o_err     <= 1'b1;
            r_last    <= r_sel;
            r_state   <= IDLE;
          end else begin
            r_wcnt    <= r_wcnt + CW'(1);
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_arb.sv
`default_nettype none
// tb_mul_arb: self-checking bench for mul_arb with a behavioural multiplier
// of programmable latency and a transaction-level round-robin model.
module tb_mul_arb;
  localparam int N    = 16;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*N-1:0] i_a;
  logic [NREQ*N-1:0] i_b;
  logic [NREQ-1:0]   o_gnt;
  logic [N-1:0]      o_res;
  logic [NREQ-1:0]   o_res_vld;
  logic              o_busy;
  logic              o_mul_vld;
  logic [N-1:0]      o_mul_a;
  logic [N-1:0]      o_mul_b;
  logic [N-1:0]      i_mul_res;
  logic              i_mul_vld;
`ifdef MUL_ARB_TIMEOUT_EN
  logic              o_err;
`endif

  logic [N-1:0] op_a [NREQ];
  logic [N-1:0] op_b [NREQ];

  int tests = 0;
  int fails = 0;
  int m_last = NREQ - 1;

  mul_arb #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (req),
    .i_a       (i_a),
    .i_b       (i_b),
    .o_gnt     (o_gnt),
    .o_res     (o_res),
    .o_res_vld (o_res_vld),
    .o_busy    (o_busy),
    .o_mul_vld (o_mul_vld),
    .o_mul_a   (o_mul_a),
    .o_mul_b   (o_mul_b),
`ifdef MUL_ARB_TIMEOUT_EN
    .o_err     (o_err),
`endif
    .i_mul_res (i_mul_res),
    .i_mul_vld (i_mul_vld)
  );

  always #5 clk = ~clk;

  always_comb begin
    i_a = '0;
    i_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      i_a[k*N +: N] = op_a[k];
      i_b[k*N +: N] = op_b[k];
    end
  end

  // Behavioural multiplier: result valid lat cycles after it sees the start.
  int           m_lat   = 3;
  logic         m_level = 1'b0;
  logic         m_never = 1'b0;
  logic         m_busy;
  int           m_cnt;
  logic [N-1:0] m_a, m_b, m_res;
  logic         m_vld;

  assign i_mul_res = m_res;
  assign i_mul_vld = m_vld & ~m_never;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_vld  <= 1'b0;
      m_cnt  <= 0;
      m_a    <= '0;
      m_b    <= '0;
      m_res  <= '0;
    end else begin
      if (!m_level) m_vld <= 1'b0;
      if (o_mul_vld) begin
        m_busy <= 1'b1;
        m_cnt  <= m_lat;
        m_a    <= o_mul_a;
        m_b    <= o_mul_b;
        m_vld  <= 1'b0;
      end else if (m_busy) begin
        if (m_cnt <= 1) begin
          m_busy <= 1'b0;
          m_vld  <= 1'b1;
          m_res  <= N'(32'(m_a) * 32'(m_b));
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] m, input int last);
    for (int i = 1; i <= NREQ; i++) begin
      if (m[(last + i) % NREQ]) return (last + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) step();
    rst = 1'b0;
    m_last = NREQ - 1;
  endtask

  // One complete job: grant, issue, result; wd >= 0 pulses that request in WAIT.
  task automatic do_job(input string tag, input bit keep, input int lat,
                        input int wd, output int glat);
    int k, n;
    logic [N-1:0] ea, eb;
    logic [NREQ-1:0] seen;
    m_lat = lat;
    glat  = 0;
    k = rr_pick(req, m_last);
    if (k < 0) begin
      tests++;
      fails++;
      $error("FAIL %s pick: observed none expected a pending requester", tag);
      return;
    end
    ea = op_a[k];
    eb = op_b[k];
    n = 0;
    do begin
      step();
      n++;
    end while (o_gnt == '0 && n < 200);
    glat = n;
    chk({tag, " gnt"}, 32'(o_gnt), 32'(1) << k);
    chk({tag, " mul_vld"}, 32'(o_mul_vld), 32'd1);
    chk({tag, " mul_a"}, 32'(o_mul_a), 32'(ea));
    chk({tag, " mul_b"}, 32'(o_mul_b), 32'(eb));
    chk({tag, " busy"}, 32'(o_busy), 32'd1);
    if (keep) begin
      op_a[k] = N'($urandom_range(255, 0));
      op_b[k] = N'($urandom_range(255, 0));
    end else begin
      req[k] = 1'b0;
    end
    step();
    n = 1;
    chk({tag, " issue_end"}, {30'd0, (o_gnt != '0), o_mul_vld}, 32'd0);
    seen = '0;
    while (o_res_vld == '0 && n < 400) begin
      if (wd >= 0 && n == 3) req[wd] = 1'b1;
      if (wd >= 0 && n == 5) req[wd] = 1'b0;
      step();
      n++;
      seen |= o_gnt;
    end
    chk({tag, " no_gnt_in_wait"}, 32'(seen), 32'd0);
    chk({tag, " res_vld"}, 32'(o_res_vld), 32'(1) << k);
    chk({tag, " res"}, 32'(o_res), (32'(ea) * 32'(eb)) & 32'hFFFF);
    chk({tag, " latency"}, 32'(n), 32'(lat + 2));
`ifdef MUL_ARB_TIMEOUT_EN
    chk({tag, " err"}, 32'(o_err), 32'd0);
`endif
    m_last = k;
  endtask

  initial begin
    int glat, n;
    logic [NREQ-1:0] seen;
    for (int k = 0; k < NREQ; k++) begin
      op_a[k] = '0;
      op_b[k] = '0;
    end

    // Reset state
    do_reset();
    chk("rst gnt", 32'(o_gnt), 32'd0);
    chk("rst res_vld", 32'(o_res_vld), 32'd0);
    chk("rst res", 32'(o_res), 32'd0);
    chk("rst mul_vld", 32'(o_mul_vld), 32'd0);
    chk("rst mul_a", 32'(o_mul_a), 32'd0);
    chk("rst mul_b", 32'(o_mul_b), 32'd0);
    chk("rst busy", 32'(o_busy), 32'd0);

    // Single request: 3*7
    op_a[0] = 16'd3;
    op_b[0] = 16'd7;
    req = 4'b0001;
    do_job("single", 1'b0, 3, -1, glat);
    chk("single glat", 32'(glat), 32'd1);
    chk("single res21", 32'(o_res), 32'd21);
    step();
    chk("single busy_after", 32'(o_busy), 32'd0);
    chk("single res_vld_clear", 32'(o_res_vld), 32'd0);

    // Simultaneous requests with a level-held multiplier valid
    do_reset();
    m_level = 1'b1;
    op_a[0] = 16'd2;  op_b[0] = 16'd5;
    op_a[2] = 16'd9;  op_b[2] = 16'd11;
    req = 4'b0101;
    do_job("sim0", 1'b0, 2, -1, glat);
    chk("sim0 res10", 32'(o_res), 32'd10);
    do_job("sim2", 1'b0, 3, -1, glat);
    chk("sim2 glat", 32'(glat), 32'd1);
    chk("sim2 res99", 32'(o_res), 32'd99);
    req = '0;
    m_level = 1'b0;
    step();

    // Round-robin fairness with random operands and latencies
    do_reset();
    for (int k = 0; k < NREQ; k++) begin
      op_a[k] = N'($urandom_range(255, 0));
      op_b[k] = N'($urandom_range(255, 0));
    end
    req = '1;
    for (int j = 0; j < 12; j++) begin
      m_level = 1'($urandom_range(1, 0));
      do_job("rr", 1'b1, int'($urandom_range(5, 1)), -1, glat);
      chk("rr glat", 32'(glat), 32'd1);
      chk("rr order", 32'(m_last), 32'(j % NREQ));
    end
    req = '0;
    m_level = 1'b0;

    // Request withdrawn while requester 3 is in WAIT
    do_reset();
    op_a[3] = 16'd13;
    op_b[3] = 16'd17;
    req = 4'b1000;
    do_job("wd", 1'b0, 10, 1, glat);
    seen = '0;
    repeat (6) begin
      step();
      seen |= o_gnt | o_res_vld;
    end
    chk("wd no_activity", 32'(seen), 32'd0);

    // Reset in the middle of WAIT
    do_reset();
    m_lat = 8;
    op_a[2] = 16'd100;
    op_b[2] = 16'd3;
    req = 4'b0100;
    n = 0;
    do begin
      step();
      n++;
    end while (o_gnt == '0 && n < 10);
    chk("mrst gnt", 32'(o_gnt), 32'b0100);
    req = '0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_last = NREQ - 1;
    chk("mrst gnt0", 32'(o_gnt), 32'd0);
    chk("mrst res_vld0", 32'(o_res_vld), 32'd0);
    chk("mrst res0", 32'(o_res), 32'd0);
    chk("mrst mul_vld0", 32'(o_mul_vld), 32'd0);
    chk("mrst mul_a0", 32'(o_mul_a), 32'd0);
    chk("mrst mul_b0", 32'(o_mul_b), 32'd0);
    chk("mrst busy0", 32'(o_busy), 32'd0);
    seen = '0;
    repeat (12) begin
      step();
      seen |= o_res_vld | o_gnt;
    end
    chk("mrst discarded", 32'(seen), 32'd0);
    op_a[0] = 16'd255;
    op_b[0] = 16'd255;
    req = 4'b0001;
    do_job("mrst_new", 1'b0, 4, -1, glat);
    chk("mrst res65025", 32'(o_res), 32'd65025);

`ifdef MUL_ARB_TIMEOUT_EN
    // Watchdog: multiplier never answers
    do_reset();
    m_never = 1'b1;
    op_a[1] = 16'd5;
    op_b[1] = 16'd6;
    req = 4'b0010;
    n = 0;
    do begin
      step();
      n++;
    end while (o_gnt == '0 && n < 10);
    chk("to gnt", 32'(o_gnt), 32'b0010);
    req = '0;
    n = 0;
    do begin
      step();
      n++;
    end while (o_res_vld == '0 && n < 200);
    chk("to latency", 32'(n), 32'd65);
    chk("to res", 32'(o_res), 32'd0);
    chk("to err", 32'(o_err), 32'd1);
    chk("to res_vld", 32'(o_res_vld), 32'b0010);
    step();
    chk("to err_clear", 32'(o_err), 32'd0);
    m_last = 1;
    m_never = 1'b0;
    op_a[2] = 16'd40;
    op_b[2] = 16'd41;
    req = 4'b0100;
    do_job("to_next", 1'b0, 3, -1, glat);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
